alu_exec_unit: RTL and testbench

- Execution-side consumer of the 3-bit ALUControl code emitted by the ALU controller.
- Accepts an operation code and two operands over a valid/ready handshake, computes the result, and holds it in a 2-entry output buffer drained by a valid/ready handshake.
- Sits between decode/operand-fetch and writeback in the multi-cycle datapath, so back-pressure from writeback never loses a result.

---
 rtl/alu_exec_unit.sv | 116 +++++++++++
 tb/tb_alu_exec_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Consumes the 3-bit ALUControl code, evaluates the operation on two
//   operands and parks the result in a 2-entry FIFO so that writeback can
//   stall without losing results.
//
//   Optional feature macro: ALU_ERR_EN
//     defined   -> out_err port present; each entry carries an illegal-code flag
//     undefined -> no out_err port; illegal codes just yield result 0, zero 1
//
//   Ports
//     clk, rst              rising-edge clock, async active-high reset
//     in_valid / in_ready   operation handshake (in_ready from registered count)
//     alu_control, a, b     operation code and operands, sampled on accept
//     out_valid / out_ready result handshake for the buffer head
//     result, zero          head result and its zero flag
//     out_err               head came from an illegal code (ALU_ERR_EN only)
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_ERR_EN
    ,
    output logic             out_err
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    // zero is kept per entry rather than derived from the head result so the
    // reset state can present result=0 with zero=0.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
`ifdef ALU_ERR_EN
        logic             err;
`endif
    } entry_t;

    entry_t     nent;
    entry_t     mem [2];
    entry_t     head;
    logic       rptr, wptr;
    logic [1:0] count;
    logic       acc, deq;

    always_comb begin
        nent = '0;
        case (alu_control)
            OP_ADD:  nent.res = a + b;
            OP_SUB:  nent.res = a - b;
            OP_AND:  nent.res = a & b;
            OP_OR:   nent.res = a | b;
            OP_SLT:  nent.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_XOR:  nent.res = a ^ b;
            default: begin
                nent.res = '0;
`ifdef ALU_ERR_EN
                nent.err = 1'b1;
`endif
            end
        endcase
        nent.zero = (nent.res == '0);
    end

    // in_ready depends only on registered count: no out_ready -> in_ready path.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign acc       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (acc) begin
                mem[wptr] <= nent;
                wptr      <= ~wptr;
            end
            if (deq) rptr <= ~rptr;
            case ({acc, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head is read straight from storage. While empty, rptr == wptr and that
    // slot is only written by the accept that makes the buffer non-empty, so
    // the outputs hold their last values; while full nothing is written.
    assign head   = mem[rptr];
    assign result = head.res;
    assign zero   = head.zero;
`ifdef ALU_ERR_EN
    assign out_err = out_valid & head.err;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero;
    logic [W-1:0] result;
`ifdef ALU_ERR_EN
    logic         out_err;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
`ifdef ALU_ERR_EN
        , .out_err(out_err)
`endif
    );

    // Reference behaviour straight from the operation table.
    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.err = 1'b0;
        case (c)
            3'd0: e.res = x + y;
            3'd1: e.res = x - y;
            3'd2: e.res = x & y;
            3'd3: e.res = x | y;
            3'd4: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            3'd5: e.res = x ^ y;
            default: begin e.res = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // One clock: update the queue model with this edge's handshakes, then
    // move 1 time unit past the edge where outputs are sampled.
    task automatic tick();
        bit acc, deq;
        @(posedge clk);
        acc = in_valid && (q.size() < 2);
        deq = (q.size() != 0) && out_ready;
        if (deq) void'(q.pop_front());
        if (acc) q.push_back(model(op, a, b));
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        tests++; if (result !== '0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %0b want 0", zero); end
`ifdef ALU_ERR_EN
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", out_err); end
`endif
        @(negedge clk); rst = 1'b0; q.delete();
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
        // accept ADD 5+7, then reset before it is drained
        in_valid = 1'b1; op = 3'd0; a = 5; b = 7; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || result !== W'(12)) begin fails++; $display("FAIL reset_pre_add: valid %0b result %h want 1/0000000c", out_valid, result); end
        rst = 1'b1; q.delete();
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_async: got %0b want 0", out_valid); end
        @(negedge clk); rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_release: ready %0b valid %0b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_basic();
        logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd4, 3'd4};
        logic [W-1:0] as  [6] = '{32'hFFFFFFFF, 32'd3, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'd1, 32'd7};
        logic [W-1:0] bs  [6] = '{32'd1, 32'd5, 32'hFFFF0000, 32'd1, 32'hFFFFFFFF, 32'd7};
        logic [W-1:0] ex  [6] = '{32'h0, 32'hFFFFFFFE, 32'h0F0FF0F0, 32'd1, 32'd0, 32'd0};
        logic         ez  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; op = ops[i]; a = as[i]; b = bs[i];
            tick();
            in_valid = 1'b0; a = '0; b = '0;
            tests++;
            if (out_valid !== 1'b1 || result !== ex[i] || zero !== ez[i]) begin
                fails++;
                $display("FAIL basic_%0d: valid %0b result %h zero %0b want 1/%h/%0b", i, out_valid, result, zero, ex[i], ez[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x1, y1, x2, y2;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd2; a = x1; b = y1; tick();
        op = 3'd3; a = x2; b = y2; tick();
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_full: ready %0b valid %0b want 0/1", in_ready, out_valid); end
        op = 3'd5; a = 32'h12345678; b = 32'h0000FFFF;  // held third op
        tick(); tick();
        tests++; if (result !== (x1 & y1) || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold: result %h ready %0b want %h/0", result, in_ready, x1 & y1); end
        out_ready = 1'b1;
        tick();
        tests++; if (result !== (x2 | y2) || in_ready !== 1'b1) begin fails++; $display("FAIL bp_drain1: result %h ready %0b want %h/1", result, in_ready, x2 | y2); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || result !== 32'h1234A987) begin fails++; $display("FAIL bp_third: valid %0b result %h want 1/1234a987", out_valid, result); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: valid %0b want 0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 3'd0; a = W'(i); b = 1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready_%0d: got %0b want 1", i, in_ready); end
            tick();
            tests++; if (out_valid !== 1'b1 || result !== W'(i + 1)) begin fails++; $display("FAIL stream_%0d: valid %0b result %h want 1/%h", i, out_valid, result, W'(i + 1)); end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_end: valid %0b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd7; a = 9; b = 9; tick();
        op = 3'd6; tick();
        in_valid = 1'b0;
        tests++; if (result !== '0 || zero !== 1'b1) begin fails++; $display("FAIL illegal_111: result %h zero %0b want 0/1", result, zero); end
`ifdef ALU_ERR_EN
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL illegal_err: got %0b want 1", out_err); end
`endif
        out_ready = 1'b1;
        tick();
        tests++; if (result !== '0 || zero !== 1'b1) begin fails++; $display("FAIL illegal_110: result %h zero %0b want 0/1", result, zero); end
        tick();
`ifdef ALU_ERR_EN
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL illegal_err_empty: got %0b want 0", out_err); end
`endif
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rnd_ready_%0d: got %0b want %0b", i, in_ready, q.size() < 2); end
            tick();
            tests++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid_%0d: got %0b want %0b", i, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                tests++;
                if (result !== q[0].res || zero !== (q[0].res == '0)) begin
                    fails++; $display("FAIL rnd_head_%0d: result %h zero %0b want %h/%0b", i, result, zero, q[0].res, q[0].res == '0);
                end
`ifdef ALU_ERR_EN
                tests++; if (out_err !== q[0].err) begin fails++; $display("FAIL rnd_err_%0d: got %0b want %0b", i, out_err, q[0].err); end
`endif
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rnd_drain: valid %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
